pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 5-stage MIPS pipeline.
- Decodes opcode/funct in ID and presents ID-stage branch/jump controls.
- Carries all remaining control bits through internal ID/EX, EX/MEM and MEM/WB control registers, with flush/bubble support for the hazard unit.
- Adds optional extended I-type ops and a multi-cycle multiply sequencer that raises its own stall.

Parameters:
- ALUCTRL_W, 3: width of ALU control code. Must be ≥3; upper bits are zero.
- EXT_OPS, 1: 1 enables bne/andi/ori/slti/mult/mflo decode; 0 decodes them as invalid.
- MUL_LAT, 4: multiply latency in cycles. Must be ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  ID-stage instruction [31:26]
- funct  in  6  ID-stage instruction [5:0]
- flush_e  in  1  hazard unit: load bubble into ID/EX
- jump_d, branch_d, branch_ne_d  out  1 each  ID-stage controls (combinational)
- invalid_d  out  1  ID opcode/funct unsupported
- reg_dst_e, alu_src_e, reg_write_e, mem_to_reg_e, md_to_reg_e  out  1 each  EX controls
- alu_control_e  out  ALUCTRL_W  EX ALU code
- md_start_e  out  1  one-cycle multiplier start
- reg_write_m, mem_to_reg_m, mem_write_m  out  1 each  MEM controls
- reg_write_w, mem_to_reg_w  out  1 each  WB controls
- md_busy  out  1  multiplier sequencer active
- md_stall  out  1  request to freeze IF/ID (OR'd into the hazard unit's stall)

Behaviour:
- Decode table (opcode → RegWrite, RegDst, ALUSrc, MemWrite, MemtoReg, Branch, Jump, ALU):
  - 000000 R-type: RegWrite=1, RegDst=1, ALU from funct.
  - 100011 lw: RegWrite=1, ALUSrc=1, MemtoReg=1, add.
  - 101011 sw: ALUSrc=1, MemWrite=1, add.
  - 000100 beq: Branch=1, sub.
  - 001000 addi: RegWrite=1, ALUSrc=1, add.
  - 000010 j: Jump=1.
  - EXT_OPS only:
    - 000101 bne: branch_ne_d=1, sub.
    - 001100 andi: RegWrite=1, ALUSrc=1, and.
    - 001101 ori: RegWrite=1, ALUSrc=1, or.
    - 001010 slti: RegWrite=1, ALUSrc=1, slt.
- ALU codes: add=010, sub=110, and=000, or=001, slt=111.
- R-type funct decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - EXT_OPS only: 011000 mult (no RegWrite, md start); 010010 mflo (RegWrite=1, RegDst=1, md_to_reg=1).
- Any other opcode/funct: all controls 0, alu code 010, invalid_d=1.
- ID/EX register:
  - Loads the decoded controls each cycle.
  - Loads all-zero (bubble) if flush_e=1 or md_stall=1.
  - Bubble takes precedence over decode.
- EX/MEM and MEM/WB registers always advance; no hold input.
- Latency: a decoded control appears at *_e 1 cycle after ID, *_m after 2 cycles, *_w after 3 cycles.
- Multiply FSM, states IDLE/BUSY:
  - IDLE → BUSY when ID/EX holds mult (md_start_e=1). Counter loads MUL_LAT-1.
  - BUSY: counter decrements each cycle; BUSY → IDLE when counter==0.
  - md_busy = (state==BUSY).
  - md_start_e = (EX-stage mult) AND IDLE.
  - md_stall = md_busy AND (ID instruction is mult or mflo). This freezes the dependent instruction; independent instructions proceed.
  - A mult in ID while IDLE does not stall.
  - A mult reaching EX while BUSY cannot occur, because md_stall blocks it.
- flush_e while a mult sits in ID/EX does not abort an already-started sequence. A mult flushed before reaching EX never starts.
- Reset (async, rst_n=0):
  - All pipeline control registers clear to 0; FSM to IDLE; counter to 0.
  - All *_e/_m/_w outputs, md_busy, md_start_e and md_stall read 0.
  - Reset mid-multiply aborts the sequence.
- ID-stage outputs (jump_d, branch_d, branch_ne_d, invalid_d) are combinational and unaffected by reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J);
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MULT, FN_MFLO);
  - ALU code constants;
  - a ctrl_t struct of control bits.
- Sub-module ctrl_decoder: purely combinational opcode/funct → ctrl_t, with EXT_OPS gating.
- Stage registers and multiply FSM live in the top.

Test Plan:
- Reset: hold rst_n=0, apply lw → all *_e/_m/_w = 0, md_busy=0. Release; lw → reg_write_e=1, alu_src_e=1, mem_to_reg_e=1, alu_control_e=010; 1 cycle later mem_to_reg_m=1; 2 cycles later mem_to_reg_w=1.
- R-type sweep: funct 100000/100010/100100/100101/101010 → alu_control_e 010/110/000/001/111, reg_dst_e=1.
- Branches: opcode 000100 → branch_d=1, same cycle. Opcode 000101 with EXT_OPS=1 → branch_ne_d=1; with EXT_OPS=0 → invalid_d=1, all controls 0.
- Flush: sw in ID with flush_e=1 → next cycle mem_write_e path zero, mem_write_m=0 one cycle later.
- Multiply (MUL_LAT=4): mult then mflo → md_start_e=1 for 1 cycle; md_busy=1 for 4 cycles; md_stall=1 while mflo waits in ID; mflo reaches EX with md_to_reg_e=1 the cycle after md_busy falls.
- Reset mid-multiply: rst_n=0 during the 2nd BUSY cycle → md_busy=0 and md_stall=0 immediately.

Source files
------------

// File: rtl/pipelined_control_unit_pkg.sv
// Shared opcode/funct/ALU constants and control bundles for the MIPS pipeline control unit.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       is_mult;
    logic       md_to_reg;
    logic       invalid;
    logic [2:0] alu;
  } ctrl_t;

  // Only the bits still needed downstream travel through each stage register.
  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_to_reg;
    logic       is_mult;
    logic       md_to_reg;
    logic [2:0] alu;
  } ex_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Bus between the hazard/datapath side and the pipeline control unit.
interface pipelined_control_unit_if #(parameter int ALUCTRL_W = 3);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 flush_e;
  logic                 jump_d, branch_d, branch_ne_d, invalid_d;
  logic                 reg_dst_e, alu_src_e, reg_write_e, mem_to_reg_e, md_to_reg_e;
  logic [ALUCTRL_W-1:0] alu_control_e;
  logic                 md_start_e;
  logic                 reg_write_m, mem_to_reg_m, mem_write_m;
  logic                 reg_write_w, mem_to_reg_w;
  logic                 md_busy, md_stall;

  modport master (
    output opcode, funct, flush_e,
    input  jump_d, branch_d, branch_ne_d, invalid_d,
    input  reg_dst_e, alu_src_e, reg_write_e, mem_to_reg_e, md_to_reg_e,
    input  alu_control_e, md_start_e,
    input  reg_write_m, mem_to_reg_m, mem_write_m,
    input  reg_write_w, mem_to_reg_w, md_busy, md_stall
  );

  modport slave (
    input  opcode, funct, flush_e,
    output jump_d, branch_d, branch_ne_d, invalid_d,
    output reg_dst_e, alu_src_e, reg_write_e, mem_to_reg_e, md_to_reg_e,
    output alu_control_e, md_start_e,
    output reg_write_m, mem_to_reg_m, mem_write_m,
    output reg_write_w, mem_to_reg_w, md_busy, md_stall
  );
endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational opcode/funct decoder; extended ops decode as invalid when EXT_OPS=0.
module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  logic ext;
  logic bad;

  assign ext = (EXT_OPS != 0);

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.alu = ALU_ADD;
    bad        = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        case (funct_i)
          FN_ADD:  ctrl_o.alu = ALU_ADD;
          FN_SUB:  ctrl_o.alu = ALU_SUB;
          FN_AND:  ctrl_o.alu = ALU_AND;
          FN_OR:   ctrl_o.alu = ALU_OR;
          FN_SLT:  ctrl_o.alu = ALU_SLT;
          FN_MULT: begin
            ctrl_o.reg_write = 1'b0;
            ctrl_o.reg_dst   = 1'b0;
            ctrl_o.is_mult   = ext;
            bad              = !ext;
          end
          FN_MFLO: begin
            ctrl_o.md_to_reg = ext;
            bad              = !ext;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu    = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_BNE: begin
        ctrl_o.branch_ne = 1'b1;
        ctrl_o.alu       = ALU_SUB;
        bad              = !ext;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu       = (opcode_i == OP_ANDI) ? ALU_AND :
                           (opcode_i == OP_ORI)  ? ALU_OR  : ALU_SLT;
        bad              = !ext;
      end
      default: bad = 1'b1;
    endcase
    // Unsupported encodings must not leak any partially decoded control bit.
    if (bad) begin
      ctrl_o         = '0;
      ctrl_o.alu     = ALU_ADD;
      ctrl_o.invalid = 1'b1;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipeline control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers and multiply sequencer.
module pipelined_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_OPS   = 1,
  parameter int MUL_LAT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_control_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT);

  ctrl_t            id_ctrl;
  ex_ctrl_t         idex_d, idex_q;
  mem_ctrl_t        exmem_q;
  wb_ctrl_t         memwb_q;
  md_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             md_busy, md_stall, md_start;

  ctrl_decoder #(.EXT_OPS(EXT_OPS)) u_dec (
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .ctrl_o   (id_ctrl)
  );

  assign md_busy  = (state_q == MD_BUSY);
  assign md_stall = md_busy && (id_ctrl.is_mult || id_ctrl.md_to_reg);
  assign md_start = idex_q.is_mult && (state_q == MD_IDLE);

  always_comb begin
    idex_d = '0;
    if (!(bus.flush_e || md_stall)) begin
      idex_d.reg_write  = id_ctrl.reg_write;
      idex_d.reg_dst    = id_ctrl.reg_dst;
      idex_d.alu_src    = id_ctrl.alu_src;
      idex_d.mem_write  = id_ctrl.mem_write;
      idex_d.mem_to_reg = id_ctrl.mem_to_reg;
      idex_d.is_mult    = id_ctrl.is_mult;
      idex_d.md_to_reg  = id_ctrl.md_to_reg;
      idex_d.alu        = id_ctrl.alu;
    end
  end

  // The counter loads MUL_LAT-1 on start so BUSY lasts exactly MUL_LAT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      idex_q             <= idex_d;
      exmem_q.reg_write  <= idex_q.reg_write;
      exmem_q.mem_to_reg <= idex_q.mem_to_reg;
      exmem_q.mem_write  <= idex_q.mem_write;
      memwb_q.reg_write  <= exmem_q.reg_write;
      memwb_q.mem_to_reg <= exmem_q.mem_to_reg;
      state_q            <= state_d;
      cnt_q              <= cnt_d;
    end
  end

  assign bus.jump_d        = id_ctrl.jump;
  assign bus.branch_d      = id_ctrl.branch;
  assign bus.branch_ne_d   = id_ctrl.branch_ne;
  assign bus.invalid_d     = id_ctrl.invalid;
  assign bus.reg_dst_e     = idex_q.reg_dst;
  assign bus.alu_src_e     = idex_q.alu_src;
  assign bus.reg_write_e   = idex_q.reg_write;
  assign bus.mem_to_reg_e  = idex_q.mem_to_reg;
  assign bus.md_to_reg_e   = idex_q.md_to_reg;
  assign bus.alu_control_e = ALUCTRL_W'(idex_q.alu);
  assign bus.md_start_e    = md_start;
  assign bus.reg_write_m   = exmem_q.reg_write;
  assign bus.mem_to_reg_m  = exmem_q.mem_to_reg;
  assign bus.mem_write_m   = exmem_q.mem_write;
  assign bus.reg_write_w   = memwb_q.reg_write;
  assign bus.mem_to_reg_w  = memwb_q.mem_to_reg;
  assign bus.md_busy       = md_busy;
  assign bus.md_stall      = md_stall;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: one DUT with extended ops, one without.
module tb_pipelined_control_unit;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  pipelined_control_unit_if #(.ALUCTRL_W(3)) bus1 ();
  pipelined_control_unit_if #(.ALUCTRL_W(3)) bus0 ();

  pipelined_control_unit #(.ALUCTRL_W(3), .EXT_OPS(1), .MUL_LAT(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  pipelined_control_unit #(.ALUCTRL_W(3), .EXT_OPS(0), .MUL_LAT(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // EX vector: {reg_dst, alu_src, reg_write, mem_to_reg, md_to_reg, alu[2:0]}
  logic [7:0] exVec1, exVec0;
  // MEM/WB vector: {reg_write_m, mem_to_reg_m, mem_write_m, reg_write_w, mem_to_reg_w}
  logic [4:0] mwVec1;
  logic [2:0] mdVec1;

  assign exVec1 = {bus1.reg_dst_e, bus1.alu_src_e, bus1.reg_write_e, bus1.mem_to_reg_e,
                   bus1.md_to_reg_e, bus1.alu_control_e};
  assign exVec0 = {bus0.reg_dst_e, bus0.alu_src_e, bus0.reg_write_e, bus0.mem_to_reg_e,
                   bus0.md_to_reg_e, bus0.alu_control_e};
  assign mwVec1 = {bus1.reg_write_m, bus1.mem_to_reg_m, bus1.mem_write_m,
                   bus1.reg_write_w, bus1.mem_to_reg_w};
  assign mdVec1 = {bus1.md_start_e, bus1.md_busy, bus1.md_stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic fl);
    bus1.opcode  = op;
    bus1.funct   = fn;
    bus1.flush_e = fl;
    bus0.opcode  = op;
    bus0.funct   = fn;
    bus0.flush_e = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    tick();
    tick();
    nChecks++;
    if (exVec1 !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL reset_ex: got %b expected %b", exVec1, 8'h00);
    end
    nChecks++;
    if ({mwVec1, mdVec1} !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL reset_mw_md: got %b expected %b", {mwVec1, mdVec1}, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    nChecks++;
    if (exVec1 !== 8'b0_1_1_1_0_010) begin
      nFails++;
      $display("[TB] FAIL lw_ex: got %b expected %b", exVec1, 8'b0_1_1_1_0_010);
    end
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    tick();
    nChecks++;
    if (mwVec1 !== 5'b110_00 || bus1.mem_to_reg_e !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL lw_mem: got %b/%b expected %b/0", mwVec1, bus1.mem_to_reg_e, 5'b11000);
    end
    tick();
    nChecks++;
    if (mwVec1 !== 5'b000_11) begin
      nFails++;
      $display("[TB] FAIL lw_wb: got %b expected %b", mwVec1, 5'b00011);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] codes[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'b000000, fns[i], 1'b0);
      tick();
      nChecks++;
      if (exVec1 !== {5'b1_0_1_0_0, codes[i]}) begin
        nFails++;
        $display("[TB] FAIL rtype_%0d: got %b expected %b", i, exVec1, {5'b10100, codes[i]});
      end
    end
  endtask

  task automatic test_ext_itype();
    logic [5:0] ops  [3] = '{6'b001100, 6'b001101, 6'b001010};
    logic [2:0] codes[3] = '{3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], 6'b000000, 1'b0);
      tick();
      nChecks++;
      if (exVec1 !== {5'b0_1_1_0_0, codes[i]} || bus0.reg_write_e !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL ext_itype_%0d: got %b/%b expected %b/0", i, exVec1, bus0.reg_write_e,
                 {5'b01100, codes[i]});
      end
    end
  endtask

  task automatic test_branches();
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    nChecks++;
    if ({bus1.branch_d, bus1.branch_ne_d, bus1.jump_d, bus1.invalid_d} !== 4'b1000) begin
      nFails++;
      $display("[TB] FAIL beq_d: got %b expected 1000",
               {bus1.branch_d, bus1.branch_ne_d, bus1.jump_d, bus1.invalid_d});
    end
    applyStimulus(6'b000101, 6'b000000, 1'b0);
    nChecks++;
    if ({bus1.branch_d, bus1.branch_ne_d, bus1.invalid_d} !== 3'b010) begin
      nFails++;
      $display("[TB] FAIL bne_ext1: got %b expected 010",
               {bus1.branch_d, bus1.branch_ne_d, bus1.invalid_d});
    end
    nChecks++;
    if ({bus0.branch_d, bus0.branch_ne_d, bus0.invalid_d} !== 3'b001) begin
      nFails++;
      $display("[TB] FAIL bne_ext0: got %b expected 001",
               {bus0.branch_d, bus0.branch_ne_d, bus0.invalid_d});
    end
    tick();
    nChecks++;
    if (exVec0 !== 8'b0_0_0_0_0_010 || exVec1 !== 8'b0_0_0_0_0_110) begin
      nFails++;
      $display("[TB] FAIL bne_ex: got %b/%b expected 00000010/00000110", exVec0, exVec1);
    end
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    nChecks++;
    if ({bus1.jump_d, bus1.branch_d, bus1.invalid_d} !== 3'b100) begin
      nFails++;
      $display("[TB] FAIL j_d: got %b expected 100", {bus1.jump_d, bus1.branch_d, bus1.invalid_d});
    end
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    tick();
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    tick();
    nChecks++;
    if (bus1.mem_write_m !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL sw_mem: got %b expected 1", bus1.mem_write_m);
    end
    applyStimulus(6'b101011, 6'b000000, 1'b1);
    tick();
    nChecks++;
    if (exVec1 !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL flush_ex: got %b expected %b", exVec1, 8'h00);
    end
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    tick();
    nChecks++;
    if (bus1.mem_write_m !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL flush_mem: got %b expected 0", bus1.mem_write_m);
    end
  endtask

  task automatic test_multiply();
    applyStimulus(6'b000000, 6'b011000, 1'b0);
    nChecks++;
    if (mdVec1 !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL mult_id_idle: got %b expected 000", mdVec1);
    end
    tick();
    nChecks++;
    if (mdVec1 !== 3'b100) begin
      nFails++;
      $display("[TB] FAIL mult_start: got %b expected 100", mdVec1);
    end
    applyStimulus(6'b001000, 6'b000000, 1'b0);
    tick();
    nChecks++;
    if (exVec1 !== 8'b0_1_1_0_0_010 || bus0.md_busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL addi_passes: got %b/%b expected 01100010/0", exVec1, bus0.md_busy);
    end
    applyStimulus(6'b000000, 6'b010010, 1'b0);
    for (int k = 0; k < 4; k++) begin
      nChecks++;
      if (mdVec1 !== 3'b011 || bus1.md_to_reg_e !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL busy_%0d: got %b/%b expected 011/0", k, mdVec1, bus1.md_to_reg_e);
      end
      tick();
    end
    nChecks++;
    if (mdVec1 !== 3'b000 || bus1.md_to_reg_e !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL busy_fall: got %b/%b expected 000/0", mdVec1, bus1.md_to_reg_e);
    end
    tick();
    nChecks++;
    if (exVec1 !== 8'b1_0_1_0_1_010) begin
      nFails++;
      $display("[TB] FAIL mflo_ex: got %b expected %b", exVec1, 8'b10101010);
    end
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    applyStimulus(6'b000000, 6'b011000, 1'b0);
    tick();
    applyStimulus(6'b001000, 6'b000000, 1'b0);
    tick();
    applyStimulus(6'b000000, 6'b010010, 1'b0);
    tick();
    nChecks++;
    if (mdVec1 !== 3'b011) begin
      nFails++;
      $display("[TB] FAIL busy2: got %b expected 011", mdVec1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (mdVec1 !== 3'b000 || exVec1 !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL reset_mid: got %b/%b expected 000/00000000", mdVec1, exVec1);
    end
    #1;
    rst_n = 1'b1;
    tick();
    nChecks++;
    if (bus1.md_to_reg_e !== 1'b1 || mdVec1 !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL after_reset_mflo: got %b/%b expected 1/000", bus1.md_to_reg_e, mdVec1);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst_n   = 1'b0;
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    test_reset();
    test_rtype();
    test_ext_itype();
    test_branches();
    test_flush();
    test_multiply();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
